// File: rtl/oled_spi_scheduler_pkg.sv
// Shared types and constants for the SSD1306 SPI link scheduler.
package oled_pkg;

    typedef enum logic [2:0] {
        PWR_HI,
        PWR_LO,
        PWR_SETTLE,
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    typedef enum logic {
        REQ_CMD,
        REQ_PIX
    } req_e;

    localparam logic DC_CMD    = 1'b0;
    localparam logic DC_DATA   = 1'b1;
    localparam logic SCLK_IDLE = 1'b1;

    // D/C level the panel expects for bytes from a given requester.
    function automatic logic req_dc(input req_e r);
        return (r == REQ_PIX) ? DC_DATA : DC_CMD;
    endfunction

endpackage

// File: rtl/oled_spi_scheduler_if.sv
// Requester streams, status flags and panel pins of the SPI link scheduler.
interface oled_spi_scheduler_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_last;

    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_byte;
    logic       pix_last;

    logic       init_done;
    logic       busy;

    logic       io_sclk;
    logic       io_sdin;
    logic       io_cs;
    logic       io_dc;
    logic       io_reset;

    // Requester side: content generators feeding the link.
    modport master (
        output cmd_valid, cmd_byte, cmd_last,
        output pix_valid, pix_byte, pix_last,
        input  cmd_ready, pix_ready, init_done, busy,
        input  io_sclk, io_sdin, io_cs, io_dc, io_reset
    );

    // Scheduler side.
    modport slave (
        input  cmd_valid, cmd_byte, cmd_last,
        input  pix_valid, pix_byte, pix_last,
        output cmd_ready, pix_ready, init_done, busy,
        output io_sclk, io_sdin, io_cs, io_dc, io_reset
    );

endinterface

// File: rtl/oled_spi_shifter.sv
// Serialises one byte MSB first: SCLK falls with each new bit, rises CLK_DIV
// cycles later, and the next bit falls CLK_DIV cycles after that.
module oled_spi_shifter
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       sclk,
    output logic       sdin,
    output logic       done
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    logic       r_active;
    logic       r_sclk;
    logic       r_sdin;
    logic [7:0] r_shreg;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic       w_half_end;

    assign w_half_end = (r_cnt == HALF_LAST);

    // Half-period counter, bit index and pin registers for the byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_sclk   <= SCLK_IDLE;
            r_sdin   <= 1'b0;
            r_shreg  <= 8'd0;
            r_cnt    <= 8'd0;
            r_bit    <= 3'd0;
        end else if (start) begin
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
            r_sdin   <= byte_in[7];
            r_shreg  <= byte_in;
            r_cnt    <= 8'd0;
            r_bit    <= 3'd7;
        end else if (r_active) begin
            if (w_half_end) begin
                r_cnt <= 8'd0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                end else if (r_bit == 3'd0) begin
                    // High phase of bit 0 finished; SCLK parks high.
                    r_active <= 1'b0;
                end else begin
                    r_bit   <= r_bit - 3'd1;
                    r_sclk  <= 1'b0;
                    r_sdin  <= r_shreg[6];
                    r_shreg <= {r_shreg[6:0], 1'b0};
                end
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign sclk = r_sclk;
    assign sdin = r_sdin;
    // Last cycle of the byte: bit 0 has risen and its high phase ends now.
    assign done = r_active & r_sclk & (r_bit == 3'd0) & w_half_end;

endmodule

// File: rtl/oled_spi_scheduler.sv
// Runs the panel power-up reset sequence, then shares the 4-wire SPI link
// between the command and pixel streams burst-by-burst with round-robin.
module oled_spi_scheduler
    import oled_pkg::*;
#(
    parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
    parameter int unsigned CLK_DIV      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    oled_spi_scheduler_if.slave  bus
);

    state_e      r_state;
    req_e        r_req;
    req_e        r_rr;
    logic        r_last;
    logic [31:0] r_pcnt;
    logic        r_cs;
    logic        r_dc;
    logic        r_reset;
    logic        r_init_done;
    logic        r_busy;

    logic        w_cmd_ready;
    logic        w_pix_ready;
    logic        w_acc_cmd;
    logic        w_acc_pix;
    logic        w_accept;
    req_e        w_acc_req;
    logic [7:0]  w_byte;
    logic        w_last;
    logic        w_phase_end;
    logic        w_sclk;
    logic        w_sdin;
    logic        w_sh_done;

    assign w_phase_end = (r_pcnt == STARTUP_WAIT - 32'd1);

    // Ready generation: arbitration in IDLE, granted requester only in LOAD/HOLD.
    always_comb begin
        w_cmd_ready = 1'b0;
        w_pix_ready = 1'b0;
        case (r_state)
            IDLE: begin
                // On contention the requester rr does not point to wins.
                w_cmd_ready = bus.cmd_valid & (~bus.pix_valid | (r_rr == REQ_PIX));
                w_pix_ready = bus.pix_valid & ~w_cmd_ready;
            end
            LOAD, HOLD: begin
                w_cmd_ready = (r_req == REQ_CMD);
                w_pix_ready = (r_req == REQ_PIX);
            end
            default: begin
                w_cmd_ready = 1'b0;
                w_pix_ready = 1'b0;
            end
        endcase
    end

    assign w_acc_cmd = w_cmd_ready & bus.cmd_valid;
    assign w_acc_pix = w_pix_ready & bus.pix_valid;
    assign w_accept  = w_acc_cmd | w_acc_pix;
    assign w_acc_req = w_acc_pix ? REQ_PIX : REQ_CMD;
    assign w_byte    = w_acc_pix ? bus.pix_byte : bus.cmd_byte;
    assign w_last    = w_acc_pix ? bus.pix_last : bus.cmd_last;

    // Power-up sequencing, burst control and registered panel/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PWR_HI;
            r_req       <= REQ_CMD;
            r_rr        <= REQ_CMD;
            r_last      <= 1'b0;
            r_pcnt      <= 32'd0;
            r_cs        <= 1'b1;
            r_dc        <= DC_CMD;
            r_reset     <= 1'b1;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                PWR_HI: begin
                    if (w_phase_end) begin
                        r_state <= PWR_LO;
                        r_pcnt  <= 32'd0;
                        r_reset <= 1'b0;
                    end else begin
                        r_pcnt <= r_pcnt + 32'd1;
                    end
                end
                PWR_LO: begin
                    if (w_phase_end) begin
                        r_state <= PWR_SETTLE;
                        r_pcnt  <= 32'd0;
                        r_reset <= 1'b1;
                    end else begin
                        r_pcnt <= r_pcnt + 32'd1;
                    end
                end
                PWR_SETTLE: begin
                    if (w_phase_end) begin
                        r_state     <= IDLE;
                        r_pcnt      <= 32'd0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_pcnt <= r_pcnt + 32'd1;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_req   <= w_acc_req;
                        r_rr    <= w_acc_req;
                        r_last  <= w_last;
                        r_cs    <= 1'b0;
                        r_dc    <= req_dc(w_acc_req);
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_sh_done) begin
                        if (r_last) begin
                            r_state <= GAP;
                            r_cs    <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_last  <= w_last;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // Burst owner keeps the link; no preemption while stalled.
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_last  <= w_last;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= PWR_HI;
                end
            endcase
        end
    end

    oled_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept),
        .byte_in (w_byte),
        .sclk    (w_sclk),
        .sdin    (w_sdin),
        .done    (w_sh_done)
    );

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.pix_ready = w_pix_ready;
    assign bus.init_done = r_init_done;
    assign bus.busy      = r_busy;
    assign bus.io_sclk   = w_sclk;
    assign bus.io_sdin   = w_sdin;
    assign bus.io_cs     = r_cs;
    assign bus.io_dc     = r_dc;
    assign bus.io_reset  = r_reset;

endmodule
